// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU issue stage: ALU op codes, ALU-op class
// codes, reset constants and small funct-classification helpers.
package alu_issue_stage_pkg;

   localparam int OP_W  = 6;
   localparam int CLS_W = 3;

   // ALU operation codes (MIPS funct encoding)
   localparam logic [OP_W-1:0] OP_ADD = 6'b100000;
   localparam logic [OP_W-1:0] OP_SUB = 6'b100010;
   localparam logic [OP_W-1:0] OP_AND = 6'b100100;
   localparam logic [OP_W-1:0] OP_OR  = 6'b100101;
   localparam logic [OP_W-1:0] OP_XOR = 6'b100110;
   localparam logic [OP_W-1:0] OP_NOR = 6'b100111;
   localparam logic [OP_W-1:0] OP_SRA = 6'b000011;
   localparam logic [OP_W-1:0] OP_SRL = 6'b000010;

   // ALU-op classes delivered by the decoder; 110/111 are unused encodings
   typedef enum logic [CLS_W-1:0] {
      CLS_ADD   = 3'b000,
      CLS_SUB   = 3'b001,
      CLS_RTYPE = 3'b010,
      CLS_AND   = 3'b011,
      CLS_OR    = 3'b100,
      CLS_XOR   = 3'b101
   } alu_class_e;

   // Reset values of the output registers
   localparam logic            RST_VALID   = 1'b0;
   localparam logic            RST_ILLEGAL = 1'b0;
   localparam logic [OP_W-1:0] RST_OP      = '0;

   // R-type funct codes the downstream ALU implements
   function automatic logic is_rtype_legal(input logic [OP_W-1:0] funct);
      return (funct == OP_ADD) || (funct == OP_SUB) || (funct == OP_AND) ||
             (funct == OP_OR)  || (funct == OP_XOR) || (funct == OP_NOR) ||
             (funct == OP_SRA) || (funct == OP_SRL);
   endfunction

   // Shift functs take rt as the shifted value and shamt as operand B
   function automatic logic is_shift_funct(input logic [OP_W-1:0] funct);
      return (funct == OP_SRA) || (funct == OP_SRL);
   endfunction

endpackage

// File: rtl/alu_issue_stage_fwd_mux.sv
// Priority forwarding select for one source operand: EX/MEM beats MEM/WB,
// register 0 is never forwarded.
module alu_issue_stage_fwd_mux #(
   parameter int N_BITS     = 32,
   parameter int N_REG_ADDR = 5
) (
   input  logic [N_REG_ADDR-1:0] i_addr,
   input  logic [N_BITS-1:0]     i_rf_data,
   input  logic                  i_exmem_we,
   input  logic [N_REG_ADDR-1:0] i_exmem_addr,
   input  logic [N_BITS-1:0]     i_exmem_data,
   input  logic                  i_memwb_we,
   input  logic [N_REG_ADDR-1:0] i_memwb_addr,
   input  logic [N_BITS-1:0]     i_memwb_data,
   output logic [N_BITS-1:0]     o_data
);

   logic w_addr_zero;
   logic w_hit_exmem;
   logic w_hit_memwb;

   assign w_addr_zero = (i_addr == '0);
   assign w_hit_exmem = i_exmem_we && (i_exmem_addr == i_addr);
   assign w_hit_memwb = i_memwb_we && (i_memwb_addr == i_addr);

   // Select the youngest in-flight producer of this register, else the RF
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned; an unassigned path would infer a latch.
      o_data = i_rf_data;
      if (!w_addr_zero) begin
         if (w_hit_exmem) begin
            o_data = i_exmem_data;
         end else if (w_hit_memwb) begin
            o_data = i_memwb_data;
         end
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Execute-issue stage in front of the combinational ALU: resolves operands
// through forwarding, maps class/funct to an ALU op, and holds one registered
// instruction behind a valid/ready handshake with flush.
module alu_issue_stage
   import alu_issue_stage_pkg::*;
#(
   parameter int N_BITS     = 32,
   parameter int N_REG_ADDR = 5
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [2:0]            i_alu_class,
   input  logic [5:0]            i_funct,
   input  logic                  i_use_imm,
   input  logic [15:0]           i_imm,
   input  logic [4:0]            i_shamt,
   input  logic [N_REG_ADDR-1:0] i_rs_addr,
   input  logic [N_REG_ADDR-1:0] i_rt_addr,
   input  logic [N_REG_ADDR-1:0] i_rd_addr,
   input  logic [N_BITS-1:0]     i_rs_data,
   input  logic [N_BITS-1:0]     i_rt_data,
   input  logic                  i_exmem_we,
   input  logic [N_REG_ADDR-1:0] i_exmem_addr,
   input  logic [N_BITS-1:0]     i_exmem_data,
   input  logic                  i_memwb_we,
   input  logic [N_REG_ADDR-1:0] i_memwb_addr,
   input  logic [N_BITS-1:0]     i_memwb_data,
   input  logic                  i_flush,
   input  logic                  i_ready,
   output logic                  o_valid,
   output logic [N_BITS-1:0]     o_a,
   output logic [N_BITS-1:0]     o_b,
   output logic [5:0]            o_op,
   output logic [N_REG_ADDR-1:0] o_rd_addr,
   output logic                  o_illegal
);

   // Output registers
   logic                  r_valid;
   logic [N_BITS-1:0]     r_a;
   logic [N_BITS-1:0]     r_b;
   logic [OP_W-1:0]       r_op;
   logic [N_REG_ADDR-1:0] r_rd_addr;
   logic                  r_illegal;

   // Combinational next-instruction values
   logic [N_BITS-1:0]     w_fwd_rs;
   logic [N_BITS-1:0]     w_fwd_rt;
   logic [N_BITS-1:0]     w_imm_sext;
   logic [N_BITS-1:0]     w_imm_zext;
   logic [N_BITS-1:0]     w_shamt_zext;
   logic                  w_imm_signed;
   logic                  w_is_shift;
   logic [OP_W-1:0]       w_op;
   logic                  w_illegal;
   logic [N_BITS-1:0]     w_a;
   logic [N_BITS-1:0]     w_b;
   logic                  w_capture;

   alu_issue_stage_fwd_mux #(
      .N_BITS     (N_BITS),
      .N_REG_ADDR (N_REG_ADDR)
   ) u_fwd_rs (
      .i_addr       (i_rs_addr),
      .i_rf_data    (i_rs_data),
      .i_exmem_we   (i_exmem_we),
      .i_exmem_addr (i_exmem_addr),
      .i_exmem_data (i_exmem_data),
      .i_memwb_we   (i_memwb_we),
      .i_memwb_addr (i_memwb_addr),
      .i_memwb_data (i_memwb_data),
      .o_data       (w_fwd_rs)
   );

   alu_issue_stage_fwd_mux #(
      .N_BITS     (N_BITS),
      .N_REG_ADDR (N_REG_ADDR)
   ) u_fwd_rt (
      .i_addr       (i_rt_addr),
      .i_rf_data    (i_rt_data),
      .i_exmem_we   (i_exmem_we),
      .i_exmem_addr (i_exmem_addr),
      .i_exmem_data (i_exmem_data),
      .i_memwb_we   (i_memwb_we),
      .i_memwb_addr (i_memwb_addr),
      .i_memwb_data (i_memwb_data),
      .o_data       (w_fwd_rt)
   );

   // No skid buffer: accept only when empty or the held entry leaves now
   assign o_ready   = !r_valid || i_ready;
   assign w_capture = i_valid && o_ready && !i_flush;

   assign w_imm_sext   = {{(N_BITS-16){i_imm[15]}}, i_imm};
   assign w_imm_zext   = {{(N_BITS-16){1'b0}}, i_imm};
   assign w_shamt_zext = {{(N_BITS-5){1'b0}}, i_shamt};
   // Arithmetic classes sign-extend the immediate, logical ones zero-extend
   assign w_imm_signed = (i_alu_class == CLS_ADD) || (i_alu_class == CLS_SUB);
   assign w_is_shift   = (i_alu_class == CLS_RTYPE) && is_shift_funct(i_funct);

   // Map ALU-op class plus funct to the ALU op code, flagging unsupported ones
   always_comb begin
      w_op      = OP_ADD;
      w_illegal = 1'b0;
      case (i_alu_class)
         CLS_ADD:   w_op = OP_ADD;
         CLS_SUB:   w_op = OP_SUB;
         CLS_AND:   w_op = OP_AND;
         CLS_OR:    w_op = OP_OR;
         CLS_XOR:   w_op = OP_XOR;
         CLS_RTYPE: begin
            if (is_rtype_legal(i_funct)) begin
               w_op = i_funct;
            end else begin
               w_illegal = 1'b1;
            end
         end
         default:   w_illegal = 1'b1;
      endcase
   end

   // Choose operands: shifts use rt/shamt, immediates replace rt for the
   // immediate-capable classes; R-type non-shifts always read rt
   always_comb begin
      w_a = w_fwd_rs;
      w_b = w_fwd_rt;
      if (w_illegal) begin
         w_a = '0;
         w_b = '0;
      end else if (w_is_shift) begin
         w_a = w_fwd_rt;
         w_b = w_shamt_zext;
      end else if (i_use_imm && (i_alu_class != CLS_RTYPE)) begin
         w_b = w_imm_signed ? w_imm_sext : w_imm_zext;
      end
   end

   // Pipeline register: flush beats capture, capture beats drain, else hold
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!i_rst_n) begin
         r_valid   <= RST_VALID;
         r_a       <= '0;
         r_b       <= '0;
         r_op      <= RST_OP;
         r_rd_addr <= '0;
         r_illegal <= RST_ILLEGAL;
      end else if (i_flush) begin
         r_valid   <= 1'b0;
         r_illegal <= 1'b0;
      end else if (w_capture) begin
         r_valid   <= 1'b1;
         r_a       <= w_a;
         r_b       <= w_b;
         r_op      <= w_op;
         r_rd_addr <= i_rd_addr;
         r_illegal <= w_illegal;
      end else if (r_valid && i_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign o_valid   = r_valid;
   assign o_a       = r_a;
   assign o_b       = r_b;
   assign o_op      = r_op;
   assign o_rd_addr = r_rd_addr;
   assign o_illegal = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the stage.
module tb_alu_issue_stage;

   localparam int N_BITS     = 32;
   localparam int N_REG_ADDR = 5;

   logic                  i_clk = 1'b0;
   logic                  i_rst_n;
   logic                  i_valid;
   logic                  o_ready;
   logic [2:0]            i_alu_class;
   logic [5:0]            i_funct;
   logic                  i_use_imm;
   logic [15:0]           i_imm;
   logic [4:0]            i_shamt;
   logic [N_REG_ADDR-1:0] i_rs_addr, i_rt_addr, i_rd_addr;
   logic [N_BITS-1:0]     i_rs_data, i_rt_data;
   logic                  i_exmem_we, i_memwb_we;
   logic [N_REG_ADDR-1:0] i_exmem_addr, i_memwb_addr;
   logic [N_BITS-1:0]     i_exmem_data, i_memwb_data;
   logic                  i_flush;
   logic                  i_ready;
   logic                  o_valid;
   logic [N_BITS-1:0]     o_a, o_b;
   logic [5:0]            o_op;
   logic [N_REG_ADDR-1:0] o_rd_addr;
   logic                  o_illegal;

   int n_tests = 0;
   int n_fail  = 0;

   // Model of what the stage should be holding
   logic                  m_valid;
   logic [31:0]           m_a, m_b;
   logic [5:0]            m_op;
   logic [4:0]            m_rd;
   logic                  m_ill;

   alu_issue_stage #(.N_BITS(N_BITS), .N_REG_ADDR(N_REG_ADDR)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_alu_class  (i_alu_class),
      .i_funct      (i_funct),
      .i_use_imm    (i_use_imm),
      .i_imm        (i_imm),
      .i_shamt      (i_shamt),
      .i_rs_addr    (i_rs_addr),
      .i_rt_addr    (i_rt_addr),
      .i_rd_addr    (i_rd_addr),
      .i_rs_data    (i_rs_data),
      .i_rt_data    (i_rt_data),
      .i_exmem_we   (i_exmem_we),
      .i_exmem_addr (i_exmem_addr),
      .i_exmem_data (i_exmem_data),
      .i_memwb_we   (i_memwb_we),
      .i_memwb_addr (i_memwb_addr),
      .i_memwb_data (i_memwb_data),
      .i_flush      (i_flush),
      .i_ready      (i_ready),
      .o_valid      (o_valid),
      .o_a          (o_a),
      .o_b          (o_b),
      .o_op         (o_op),
      .o_rd_addr    (o_rd_addr),
      .o_illegal    (o_illegal)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Operand value after forwarding, straight from the hazard rules
   function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] rf);
      if (addr == 0)                               return rf;
      if (i_exmem_we && i_exmem_addr == addr)      return i_exmem_data;
      if (i_memwb_we && i_memwb_addr == addr)      return i_memwb_data;
      return rf;
   endfunction

   // What the stage should capture from the current inputs
   task automatic model_instr(output logic [31:0] a, output logic [31:0] b,
                              output logic [5:0] op, output logic ill);
      logic [31:0] rs, rt;
      rs  = fwd(i_rs_addr, i_rs_data);
      rt  = fwd(i_rt_addr, i_rt_data);
      ill = 1'b0;
      a   = rs;
      if (!i_use_imm)             b = rt;
      else if (i_alu_class <= 1)  b = {{16{i_imm[15]}}, i_imm};
      else                        b = {16'h0, i_imm};
      case (i_alu_class)
         3'd0: op = 6'h20;
         3'd1: op = 6'h22;
         3'd3: op = 6'h24;
         3'd4: op = 6'h25;
         3'd5: op = 6'h26;
         3'd2: begin
            op = i_funct;
            if (!(i_funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02}))
               ill = 1'b1;
            if (i_funct == 6'h03 || i_funct == 6'h02) begin
               a = rt;
               b = {27'h0, i_shamt};
            end
         end
         default: ill = 1'b1;
      endcase
      if (ill) begin
         op = 6'h20;
         a  = 32'h0;
         b  = 32'h0;
      end
   endtask

   // One clock: check ready against current inputs, advance model, check outputs
   task automatic cycle();
      logic        cap;
      logic [31:0] ea, eb;
      logic [5:0]  eop;
      logic        eill;
      #1;
      check("ready", 32'(o_ready), 32'(!m_valid || i_ready));
      cap = i_valid && (!m_valid || i_ready) && !i_flush;
      model_instr(ea, eb, eop, eill);
      @(posedge i_clk);
      if (i_flush) begin
         m_valid = 1'b0;
         m_ill   = 1'b0;
      end else if (cap) begin
         m_valid = 1'b1;
         m_a     = ea;
         m_b     = eb;
         m_op    = eop;
         m_rd    = i_rd_addr;
         m_ill   = eill;
      end else if (m_valid && i_ready) begin
         m_valid = 1'b0;
      end
      @(negedge i_clk);
      check("valid",   32'(o_valid),   32'(m_valid));
      check("illegal", 32'(o_illegal), 32'(m_ill));
      if (m_valid) begin
         check("a",  o_a, m_a);
         check("b",  o_b, m_b);
         check("op", 32'(o_op), 32'(m_op));
         check("rd", 32'(o_rd_addr), 32'(m_rd));
      end
   endtask

   task automatic set_instr(input logic [2:0] cls, input logic [5:0] funct,
                            input logic use_imm, input logic [15:0] imm,
                            input logic [4:0] shamt, input logic [4:0] rs_a,
                            input logic [4:0] rt_a, input logic [31:0] rs_d,
                            input logic [31:0] rt_d);
      i_valid     = 1'b1;
      i_alu_class = cls;
      i_funct     = funct;
      i_use_imm   = use_imm;
      i_imm       = imm;
      i_shamt     = shamt;
      i_rs_addr   = rs_a;
      i_rt_addr   = rt_a;
      i_rd_addr   = 5'($urandom_range(0, 31));
      i_rs_data   = rs_d;
      i_rt_data   = rt_d;
   endtask

   task automatic no_fwd();
      i_exmem_we = 1'b0; i_exmem_addr = '0; i_exmem_data = '0;
      i_memwb_we = 1'b0; i_memwb_addr = '0; i_memwb_data = '0;
   endtask

   task automatic randomize_inputs();
      logic [5:0] legal [8];
      legal = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
      i_valid      = ($urandom_range(0, 9) < 7);
      i_alu_class  = 3'($urandom_range(0, 7));
      i_funct      = ($urandom_range(0, 3) != 0) ? legal[$urandom_range(0, 7)]
                                                 : 6'($urandom);
      // R-type instructions never carry an immediate
      i_use_imm    = (i_alu_class != 3'd2) && $urandom_range(0, 1) == 1;
      i_imm        = 16'($urandom);
      i_shamt      = 5'($urandom);
      i_rs_addr    = 5'($urandom_range(0, 3));
      i_rt_addr    = 5'($urandom_range(0, 3));
      i_rd_addr    = 5'($urandom);
      i_rs_data    = $urandom;
      i_rt_data    = $urandom;
      i_exmem_we   = $urandom_range(0, 1) == 1;
      i_exmem_addr = 5'($urandom_range(0, 3));
      i_exmem_data = $urandom;
      i_memwb_we   = $urandom_range(0, 1) == 1;
      i_memwb_addr = 5'($urandom_range(0, 3));
      i_memwb_data = $urandom;
      i_flush      = ($urandom_range(0, 9) == 0);
      i_ready      = ($urandom_range(0, 3) != 0);
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
      set_instr(3'd0, 6'h0, 1'b0, 16'h0, 5'h0, 5'd0, 5'd0, 32'h0, 32'h0);
      i_valid = 1'b0;
      no_fwd();
      m_valid = 1'b0; m_a = '0; m_b = '0; m_op = '0; m_rd = '0; m_ill = 1'b0;
      repeat (2) @(negedge i_clk);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_a",     o_a,          32'h0);
      check("rst_b",     o_b,          32'h0);
      check("rst_op",    32'(o_op),    32'h0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Plain R-type add, no forwarding
      set_instr(3'd2, 6'h20, 1'b0, 16'h0, 5'h0, 5'd1, 5'd2, 32'd10, 32'd20);
      cycle();
      // Logical immediate zero-extends, arithmetic immediate sign-extends
      set_instr(3'd3, 6'h0, 1'b1, 16'hFFF0, 5'h0, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'h5);
      cycle();
      set_instr(3'd0, 6'h0, 1'b1, 16'hFFF0, 5'h0, 5'd1, 5'd2, 32'hFFFF_FFFF, 32'h5);
      cycle();
      // EX/MEM wins over MEM/WB; register 0 never forwards
      set_instr(3'd0, 6'h0, 1'b0, 16'h0, 5'h0, 5'd5, 5'd6, 32'h11, 32'h22);
      i_exmem_we = 1'b1; i_exmem_addr = 5'd5; i_exmem_data = 32'hAA;
      i_memwb_we = 1'b1; i_memwb_addr = 5'd5; i_memwb_data = 32'hBB;
      cycle();
      i_rs_addr = 5'd0; i_exmem_addr = 5'd0; i_memwb_addr = 5'd0;
      cycle();
      no_fwd();
      // Shift takes rt and shamt; unsupported funct is illegal
      set_instr(3'd2, 6'h03, 1'b1, 16'h1234, 5'd4, 5'd1, 5'd2, 32'h7, 32'h8000_0000);
      cycle();
      set_instr(3'd2, 6'h00, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 32'h7, 32'h9);
      cycle();
      set_instr(3'd7, 6'h20, 1'b0, 16'h0, 5'd0, 5'd1, 5'd2, 32'h7, 32'h9);
      cycle();

      // Capture, stall with churn on all inputs, flush in the second stall cycle
      set_instr(3'd1, 6'h0, 1'b0, 16'h0, 5'd0, 5'd3, 5'd4, 32'h100, 32'h1);
      cycle();
      i_ready = 1'b0;
      set_instr(3'd4, 6'h0, 1'b1, 16'h8001, 5'd0, 5'd3, 5'd4, 32'h200, 32'h2);
      i_exmem_we = 1'b1; i_exmem_addr = 5'd3; i_exmem_data = 32'hDEAD;
      cycle();
      i_flush = 1'b1; i_exmem_data = 32'hBEEF;
      cycle();
      i_flush = 1'b0; i_valid = 1'b0;
      cycle();
      no_fwd();
      i_ready = 1'b1;

      // Asynchronous reset while stalled clears everything before the next edge
      set_instr(3'd5, 6'h0, 1'b1, 16'h00FF, 5'd0, 5'd1, 5'd2, 32'hF0F0, 32'h3);
      cycle();
      i_ready = 1'b0;
      cycle();
      #2 i_rst_n = 1'b0;
      #1;
      m_valid = 1'b0; m_ill = 1'b0;
      check("arst_valid",   32'(o_valid),   32'h0);
      check("arst_a",       o_a,            32'h0);
      check("arst_b",       o_b,            32'h0);
      check("arst_op",      32'(o_op),      32'h0);
      check("arst_rd",      32'(o_rd_addr), 32'h0);
      check("arst_illegal", 32'(o_illegal), 32'h0);
      #1 i_rst_n = 1'b1;
      @(negedge i_clk);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
